// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants and types for the hazard/stall controller.
// Used by hazard_stall_unit and md_occupancy_tracker.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W              = 5;
    localparam int unsigned MD_CNT_W           = 8;
    localparam int unsigned PERF_W             = 32;
    localparam int unsigned MD_LATENCY_DEFAULT = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_occupancy_tracker.sv
// Multiply/divide occupancy FSM: tracks HI/LO busy window after a MULT/DIV
// issues from EX and pulses md_done_o in the last busy cycle.
module md_occupancy_tracker
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    output logic md_busy_o,
    output logic md_done_o,
    output logic cnt_nz_o
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while busy is ignored; the stall logic should make it impossible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy_o = (state_q == MD_BUSY);
    assign md_done_o = (state_q == MD_BUSY) && (cnt_q == MD_CNT_W'(1));
    assign cnt_nz_o  = (cnt_q != '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && (state_q == MD_BUSY) && md_start_i) begin
            $error("md_occupancy_tracker: MDStart while busy, ignored");
        end
    end
`endif

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / multiply-divide stall and taken-branch flush controller.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEXMemRead,
    input  logic [REG_W-1:0] IDEXRt,
    input  logic [REG_W-1:0] IFIDRs,
    input  logic [REG_W-1:0] IFIDRt,
    input  logic             IFIDUsesRt,
    input  logic             IFIDMD,
    input  logic             MDStart,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MDBusy,
    output logic             MDDone
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      LUStallCnt,
    output logic [31:0]      MDStallCnt,
    output logic [31:0]      FlushCnt
`endif
);

    logic md_cnt_nz;
    logic lu_haz;
    logic md_haz;
    logic stall;

    md_occupancy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_occupancy_tracker (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (MDStart),
        .md_busy_o  (MDBusy),
        .md_done_o  (MDDone),
        .cnt_nz_o   (md_cnt_nz)
    );

    assign lu_haz = IDEXMemRead && (IDEXRt != REG_ZERO) &&
                    ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));
    assign md_haz = IFIDMD && MDBusy && md_cnt_nz;
    assign stall  = (lu_haz || md_haz) && !BranchTaken;

    // Taken branch wins: the instruction that would stall is being discarded.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (BranchTaken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [PERF_W-1:0] md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] fl_cnt_q, fl_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q <= '0;
            md_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            md_cnt_q <= md_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    // A cycle with both hazards is attributed to load-use only.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        md_cnt_d = md_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (BranchTaken) begin
            fl_cnt_d = fl_cnt_q + PERF_W'(1);
        end else if (lu_haz) begin
            lu_cnt_d = lu_cnt_q + PERF_W'(1);
        end else if (md_haz) begin
            md_cnt_d = md_cnt_q + PERF_W'(1);
        end
    end

    assign LUStallCnt = lu_cnt_q;
    assign MDStallCnt = md_cnt_q;
    assign FlushCnt   = fl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus
// randomized traffic checked against a cycle-count based reference model.
module tb_hazard_stall_unit;

    localparam int unsigned L = 4;

    logic       clk;
    logic       rst;
    logic       IDEXMemRead;
    logic [4:0] IDEXRt;
    logic [4:0] IFIDRs;
    logic [4:0] IFIDRt;
    logic       IFIDUsesRt;
    logic       IFIDMD;
    logic       MDStart;
    logic       BranchTaken;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IFIDFlush;
    logic       IDEXFlush;
    logic       MDBusy;
    logic       MDDone;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] LUStallCnt;
    logic [31:0] MDStallCnt;
    logic [31:0] FlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: cycle index, cycle of last MULT/DIV issue, counts.
    int          cyc      = 0;
    int          md_issue = -1000;
    int unsigned m_lu     = 0;
    int unsigned m_md     = 0;
    int unsigned m_fl     = 0;

    logic [5:0] outs;
    assign outs = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy, MDDone};

    hazard_stall_unit #(
        .MD_LATENCY (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IDEXMemRead (IDEXMemRead),
        .IDEXRt      (IDEXRt),
        .IFIDRs      (IFIDRs),
        .IFIDRt      (IFIDRt),
        .IFIDUsesRt  (IFIDUsesRt),
        .IFIDMD      (IFIDMD),
        .MDStart     (MDStart),
        .BranchTaken (BranchTaken),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IFIDFlush   (IFIDFlush),
        .IDEXFlush   (IDEXFlush),
        .MDBusy      (MDBusy),
        .MDDone      (MDDone)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .LUStallCnt  (LUStallCnt),
        .MDStallCnt  (MDStallCnt),
        .FlushCnt    (FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_busy();
        return (cyc > md_issue) && (cyc <= md_issue + int'(L) - 1);
    endfunction

    function automatic bit m_lu_haz();
        return IDEXMemRead && (IDEXRt != 5'd0) &&
               ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));
    endfunction

    function automatic logic [5:0] model_outs();
        bit mh, s;
        mh = IFIDMD && m_busy();
        s  = (m_lu_haz() || mh) && !BranchTaken;
        return {!s, !s, BranchTaken, BranchTaken || s,
                m_busy(), m_busy() && (cyc == md_issue + int'(L) - 1)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_issue = -1000;
            m_lu = 0;
            m_md = 0;
            m_fl = 0;
        end else begin
            if (BranchTaken)                   m_fl++;
            else if (m_lu_haz())               m_lu++;
            else if (IFIDMD && m_busy())       m_md++;
            if (MDStart && !m_busy()) md_issue = cyc;
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        IDEXMemRead = 0; IDEXRt = 0; IFIDRs = 0; IFIDRt = 0;
        IFIDUsesRt = 0; IFIDMD = 0; MDStart = 0; BranchTaken = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #4;
        checks++;
        if (outs !== 6'b110000) begin
            errors++;
            $display("FAIL reset: outs=%b expected=%b", outs, 6'b110000);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [5:0] exp_tab [6];
        exp_tab = '{6'b000100, 6'b110000, 6'b110000, 6'b110000, 6'b000100, 6'b000100};
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            case (i)
                0: begin IDEXMemRead = 1; IDEXRt = 8; IFIDRs = 8; end
                1: begin IFIDRs = 8; end
                2: begin IDEXMemRead = 1; end
                3: begin IDEXMemRead = 1; IDEXRt = 9; IFIDRt = 9; end
                4: begin IDEXMemRead = 1; IDEXRt = 9; IFIDRt = 9; IFIDUsesRt = 1; end
                default: begin IDEXMemRead = 1; IDEXRt = 31; IFIDRs = 31; IFIDRt = 2; end
            endcase
            #4;
            checks++;
            if (outs !== exp_tab[i]) begin
                errors++;
                $display("FAIL load_use[%0d]: outs=%b expected=%b", i, outs, exp_tab[i]);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_md_latency();
        logic [5:0] exp_tab [5];
        exp_tab = '{6'b110000, 6'b000110, 6'b000110, 6'b000111, 6'b110000};
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            MDStart = (i == 0);
            IFIDMD  = (i != 0);
            #4;
            checks++;
            if (outs !== exp_tab[i]) begin
                errors++;
                $display("FAIL md_latency[T+%0d]: outs=%b expected=%b", i, outs, exp_tab[i]);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_branch_priority();
        logic [5:0] exp_tab [5];
        exp_tab = '{6'b111100, 6'b110000, 6'b111110, 6'b000110, 6'b000111};
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            case (i)
                0: begin IDEXMemRead = 1; IDEXRt = 5; IFIDRs = 5; BranchTaken = 1; end
                1: begin MDStart = 1; end
                2: begin IFIDMD = 1; IDEXMemRead = 1; IDEXRt = 3; IFIDRs = 3; BranchTaken = 1; end
                default: begin IFIDMD = 1; IDEXMemRead = (i == 3); IDEXRt = 3; IFIDRs = 3; end
            endcase
            #4;
            checks++;
            if (outs !== exp_tab[i]) begin
                errors++;
                $display("FAIL branch_priority[%0d]: outs=%b expected=%b", i, outs, exp_tab[i]);
            end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_md();
        drive_idle();
        MDStart = 1;
        next_cycle();
        drive_idle();
        next_cycle();
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if ({MDBusy, MDDone} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_md: busy/done=%b expected=00", {MDBusy, MDDone});
        end
        #2;
        rst = 1'b0;
        next_cycle();
        IFIDMD = 1;
        #4;
        checks++;
        if (outs !== 6'b110000) begin
            errors++;
            $display("FAIL reset_mid_md_mfhi: outs=%b expected=%b", outs, 6'b110000);
        end
        next_cycle();
        drive_idle();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        rst = 1'b1;
        drive_idle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            if (i == 0 || i == 2 || i == 5) begin IDEXMemRead = 1; IDEXRt = 7; IFIDRs = 7; end
            if (i == 3 || i == 6) BranchTaken = 1;
            next_cycle();
        end
        drive_idle();
        checks++;
        if ({LUStallCnt, MDStallCnt, FlushCnt} !== {32'd3, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL perf_directed: lu=%0d md=%0d fl=%0d expected 3 0 2",
                     LUStallCnt, MDStallCnt, FlushCnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [5:0] exp;
        for (int i = 0; i < 400; i++) begin
            IDEXMemRead = 1'($urandom_range(0, 1));
            IDEXRt      = 5'($urandom_range(0, 3));
            IFIDRs      = 5'($urandom_range(0, 3));
            IFIDRt      = 5'($urandom_range(0, 3));
            IFIDUsesRt  = 1'($urandom_range(0, 1));
            IFIDMD      = 1'($urandom_range(0, 1));
            BranchTaken = ($urandom_range(0, 4) == 0);
            MDStart     = !m_busy() && ($urandom_range(0, 3) == 0);
            #4;
            exp = model_outs();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL random[%0d]: outs=%b expected=%b", i, outs, exp);
            end
            next_cycle();
        end
        drive_idle();
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({LUStallCnt, MDStallCnt, FlushCnt} !== {m_lu, m_md, m_fl}) begin
            errors++;
            $display("FAIL perf_random: lu=%0d md=%0d fl=%0d expected %0d %0d %0d",
                     LUStallCnt, MDStallCnt, FlushCnt, m_lu, m_md, m_fl);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_md_latency();
        test_branch_priority();
        test_reset_mid_md();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that handles the hazards operand forwarding cannot resolve. It sits beside the forwarding logic in the ID/EX boundary region. It stalls the front end on load-use dependences and on accesses to an in-flight multi-cycle multiply/divide, and flushes IF/ID and ID/EX on taken branches. It also tracks multiply/divide occupancy with a cycle counter, so HI/LO readers in ID wait until the result is valid.

## Interface
Parameters:
- MD_LATENCY, 32: cycles a MULT/DIV occupies the HI/LO unit after issue from EX; legal range 2..255.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- IDEXMemRead  input  1  the instruction in EX is a load.
- IDEXRt  input  5  destination register of the load in EX.
- IFIDRs  input  5  source register Rs of the instruction in ID.
- IFIDRt  input  5  source register Rt of the instruction in ID.
- IFIDUsesRt  input  1  the ID instruction reads Rt as a source (R-type, store, branch).
- IFIDMD  input  1  the ID instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO.
- MDStart  input  1  a MULT/DIV is in EX this cycle.
- BranchTaken  input  1  the branch or jump resolved in EX is taken.
- PCWrite  output  1  PC load enable.
- IFIDWrite  output  1  IF/ID register load enable.
- IFIDFlush  output  1  zero the IF/ID register.
- IDEXFlush  output  1  insert a bubble into ID/EX (control bits cleared).
- MDBusy  output  1  the multiply/divide unit is occupied.
- MDDone  output  1  one-cycle pulse in the cycle HI/LO becomes valid.

## Operation
- Load-use hazard LU = IDEXMemRead & (IDEXRt != 0) & ((IDEXRt == IFIDRs) | (IFIDUsesRt & (IDEXRt == IFIDRt))).
- MD hazard MH = IFIDMD & (state == BUSY) & (cnt != 0).
- Stall S = (LU | MH) & ~BranchTaken.
  - When S: PCWrite=0, IFIDWrite=0, IDEXFlush=1.
- Branch: when BranchTaken, IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1.
  - BranchTaken has priority over every stall, because the stalled instruction is being discarded.
- Otherwise: PCWrite=1, IFIDWrite=1, both flushes 0.
- FSM, 2 states, registered:
  - IDLE: on MDStart, go to BUSY and load cnt = MD_LATENCY-1.
  - BUSY: cnt decrements each cycle.
    - When cnt == 1: next state IDLE; MDDone asserts for that cycle (HI/LO valid next edge).
    - MDStart in BUSY cannot occur, because MH stalls any MD instruction in ID. If it is asserted anyway, it is ignored; it is flagged in simulation with $error.
- MDBusy = (state == BUSY).
- cnt width is 8 bits; it never wraps because its only values are MD_LATENCY-1 down to 1.
- The 1-cycle load-use stall needs no state: after one bubble the load is in MEM and forwarding covers it.
- Register $zero never causes a stall.

## Timing
- All stall/flush outputs are combinational from inputs and registered state, valid in the same cycle as their cause.
- MULT issued from EX in cycle T: MDBusy is high in T+1..T+MD_LATENCY-1, MDDone is high in T+MD_LATENCY-1, and MDBusy is low in T+MD_LATENCY.
  - MFHI in ID during T+1..T+MD_LATENCY-1 stalls; it advances in T+MD_LATENCY.
- Reset, including mid-operation:
  - state=IDLE, cnt=0, MDBusy=0, MDDone=0.
  - With idle inputs: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
  - An in-flight MD result is abandoned.
- BranchTaken while BUSY: flushes occur and the counter continues unaffected, because the issued MULT/DIV is architecturally committed.
- LU and MH at once: a single stall cycle per cycle; the stall holds until both clear.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs LUStallCnt[31:0], MDStallCnt[31:0] and FlushCnt[31:0].
  - Each counter increments once per cycle in which its cause drives a stall or flush.
  - Counters wrap modulo 2^32 and reset to 0.
  - If LU and MH are both true in one cycle, only LUStallCnt increments.
- HAZARD_PERF_CNT_EN undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package: MD state encoding (MD_IDLE=1'b0, MD_BUSY=1'b1), the default MD_LATENCY constant, and the register-zero constant.
- One sub-module, md_occupancy_tracker: the FSM plus cnt, producing MDBusy, MDDone and cnt_nz.
- The top level holds the combinational hazard and priority logic and the optional performance counters.

## Test plan
- LW with IDEXRt=8; ID ADD with IFIDRs=8 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; the next cycle is clean.
- LW with IDEXRt=0 and IFIDRs=0 -> no stall. IDEXRt=9, IFIDRt=9, IFIDUsesRt=0 -> no stall.
- MD_LATENCY=4: MDStart at T, then MFLO in ID from T+1 -> stalled in T+1..T+3, MDDone at T+3, advances at T+4.
- LU and BranchTaken in the same cycle -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, no stall.
- rst asserted at T+2 of a MULT -> MDBusy=0 immediately (async); with rst released and MFHI in ID -> no stall.
- With HAZARD_PERF_CNT_EN defined: 3 load-use events and 2 taken branches -> LUStallCnt=3, FlushCnt=2.
